// File: rtl/rope_pkg.sv
// rope_pkg: shared types and constants for the rope 2-D mover.
// Edge handling modes, FSM states and the speed width.
package rope_pkg;

    localparam int SPD_W = 16;

    typedef enum logic [1:0] {
        EDGE_BOUNCE = 2'd0,
        EDGE_WRAP   = 2'd1,
        EDGE_STOP   = 2'd2
    } edge_mode_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PAUSED  = 2'd1,
        STOPPED = 2'd2
    } move_state_t;

endpackage

// File: rtl/rope_axis.sv
// rope_axis: one axis of the mover.
// Fixed-point accumulate, bound handling and direction-toggle flag.
module rope_axis
    import rope_pkg::*;
#(
    parameter int         FRAC_BITS = 6,
    parameter int         POS_W     = 11,
    parameter int         MIN       = 0,
    parameter int         MAX       = 639,
    parameter edge_mode_t EDGE_MODE = EDGE_BOUNCE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    sof,
    input  logic                    run,
    input  logic                    paused,
    input  logic                    stop_all,
    input  logic                    toggle,
    input  logic signed [POS_W-1:0] init_pos,
    input  logic signed [SPD_W-1:0] init_speed,
    output logic signed [POS_W-1:0] pos_pix,
    output logic signed [SPD_W-1:0] speed,
    output logic                    hit,
    output logic                    stop_hit
);

    localparam int P_W = POS_W + FRAC_BITS + 1;
    localparam int S_W = P_W + 1;

    localparam logic signed [S_W-1:0] LO_S = S_W'(MIN * (2 ** FRAC_BITS));
    localparam logic signed [S_W-1:0] HI_S = S_W'(MAX * (2 ** FRAC_BITS));
    localparam logic signed [P_W-1:0] LO_P = P_W'(MIN * (2 ** FRAC_BITS));
    localparam logic signed [P_W-1:0] HI_P = P_W'(MAX * (2 ** FRAC_BITS));

    logic signed [P_W-1:0]   pos_q;
    logic signed [P_W-1:0]   pos_d;
    logic signed [SPD_W-1:0] spd_q;
    logic signed [SPD_W-1:0] spd_d;
    logic                    flag_q;
    logic                    flag_d;
    logic                    hit_q;
    logic                    hit_d;

    logic signed [S_W-1:0]   sum_w;
    logic signed [P_W-1:0]   init_fix;
    logic                    over;
    logic                    under;
    logic                    evt;
    logic                    tog_ok;
    logic                    step;

    assign init_fix = P_W'($signed({init_pos, {FRAC_BITS{1'b0}}}));

    // Next-state of position, speed, toggle flag and edge pulse
    always_comb begin
        sum_w    = S_W'(pos_q) + S_W'(spd_q);
        over     = sum_w > HI_S;
        under    = sum_w < LO_S;
        step     = run && sof;
        evt      = step && (spd_q != '0) && (over || under);
        stop_hit = evt && (EDGE_MODE == EDGE_STOP);
        tog_ok   = run && toggle && (!flag_q || sof);

        pos_d  = pos_q;
        spd_d  = spd_q;
        flag_d = flag_q;
        hit_d  = 1'b0;

        if (step) begin
            if (!(over || under)) begin
                pos_d = sum_w[P_W-1:0];
            end else if (evt) begin
                hit_d = 1'b1;
                case (EDGE_MODE)
                    EDGE_WRAP: begin
                        pos_d = over ? LO_P : HI_P;
                    end
                    EDGE_STOP: begin
                        pos_d = over ? HI_P : LO_P;
                    end
                    default: begin
                        pos_d = over ? HI_P : LO_P;
                        spd_d = -spd_q;
                    end
                endcase
            end
        end

        if (tog_ok) begin
            spd_d = -spd_d;
        end

        if (stop_all) begin
            spd_d = '0;
        end

        if (sof || paused) begin
            flag_d = 1'b0;
        end else if (tog_ok) begin
            flag_d = 1'b1;
        end

        if (load) begin
            pos_d  = init_fix;
            spd_d  = init_speed;
            flag_d = 1'b0;
            hit_d  = 1'b0;
        end
    end

    // Axis registers with synchronous reset to the initial inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q  <= init_fix;
            spd_q  <= init_speed;
            flag_q <= 1'b0;
            hit_q  <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            spd_q  <= spd_d;
            flag_q <= flag_d;
            hit_q  <= hit_d;
        end
    end

    assign pos_pix = pos_q[POS_W+FRAC_BITS-1:FRAC_BITS];
    assign speed   = spd_q;
    assign hit     = hit_q;

endmodule

// File: rtl/rope_move2d.sv
// rope_move2d: frame-stepped 2-D object mover.
// Two rope_axis instances under a RUN/PAUSED/STOPPED FSM.
module rope_move2d
    import rope_pkg::*;
#(
    parameter int         FRAC_BITS = 6,
    parameter int         POS_W     = 11,
    parameter int         X_MIN     = 0,
    parameter int         X_MAX     = 639,
    parameter int         Y_MIN     = 0,
    parameter int         Y_MAX     = 479,
    parameter edge_mode_t EDGE_MODE = EDGE_BOUNCE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    startOfFrame,
    input  logic                    enable,
    input  logic                    load,
    input  logic                    dirToggleX,
    input  logic                    dirToggleY,
    input  logic signed [POS_W-1:0] INITIAL_X,
    input  logic signed [POS_W-1:0] INITIAL_Y,
    input  logic signed [SPD_W-1:0] X_SPEED,
    input  logic signed [SPD_W-1:0] Y_SPEED,
    output logic signed [POS_W-1:0] topLeftX,
    output logic signed [POS_W-1:0] topLeftY,
    output logic signed [SPD_W-1:0] speedX,
    output logic signed [SPD_W-1:0] speedY,
    output logic                    edgeHitX,
    output logic                    edgeHitY,
    output logic [1:0]              state
);

    move_state_t state_q;
    move_state_t state_d;

    logic run;
    logic paused;
    logic stop_x;
    logic stop_y;
    logic stop_any;

    assign run      = (state_q == RUN);
    assign paused   = (state_q == PAUSED);
    assign stop_any = stop_x | stop_y;

    rope_axis #(
        .FRAC_BITS (FRAC_BITS),
        .POS_W     (POS_W),
        .MIN       (X_MIN),
        .MAX       (X_MAX),
        .EDGE_MODE (EDGE_MODE)
    ) u_axis_x (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .sof        (startOfFrame),
        .run        (run),
        .paused     (paused),
        .stop_all   (stop_any),
        .toggle     (dirToggleX),
        .init_pos   (INITIAL_X),
        .init_speed (X_SPEED),
        .pos_pix    (topLeftX),
        .speed      (speedX),
        .hit        (edgeHitX),
        .stop_hit   (stop_x)
    );

    rope_axis #(
        .FRAC_BITS (FRAC_BITS),
        .POS_W     (POS_W),
        .MIN       (Y_MIN),
        .MAX       (Y_MAX),
        .EDGE_MODE (EDGE_MODE)
    ) u_axis_y (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .sof        (startOfFrame),
        .run        (run),
        .paused     (paused),
        .stop_all   (stop_any),
        .toggle     (dirToggleY),
        .init_pos   (INITIAL_Y),
        .init_speed (Y_SPEED),
        .pos_pix    (topLeftY),
        .speed      (speedY),
        .hit        (edgeHitY),
        .stop_hit   (stop_y)
    );

    // Next state: stop hit wins inside RUN, load overrides everything
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (stop_any) begin
                    state_d = STOPPED;
                end else if (!enable) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (enable) begin
                    state_d = RUN;
                end
            end
            STOPPED: begin
                state_d = STOPPED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (load) begin
            state_d = enable ? RUN : PAUSED;
        end
    end

    // State register, synchronous reset into RUN
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_rope_move2d.sv
// tb_rope_move2d: directed bench for rope_move2d.
// Four instances: default bounce, bounce at X_MAX=300, wrap, stop.
module tb_rope_move2d;
    import rope_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic sof;
    logic enable;
    logic load;
    logic tgx;
    logic tgy;
    logic signed [10:0] ix;
    logic signed [10:0] iy;
    logic signed [15:0] sx;
    logic signed [15:0] sy;

    logic signed [10:0] tlx [4];
    logic signed [10:0] tly [4];
    logic signed [15:0] spx [4];
    logic signed [15:0] spy [4];
    logic               hx  [4];
    logic               hy  [4];
    logic [1:0]         st  [4];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int XMAX = (g == 1) ? 300 : 639;
        localparam edge_mode_t EM = edge_mode_t'((g == 2) ? 1 : ((g == 3) ? 2 : 0));
        rope_move2d #(
            .X_MAX     (XMAX),
            .EDGE_MODE (EM)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .startOfFrame (sof),
            .enable       (enable),
            .load         (load),
            .dirToggleX   (tgx),
            .dirToggleY   (tgy),
            .INITIAL_X    (ix),
            .INITIAL_Y    (iy),
            .X_SPEED      (sx),
            .Y_SPEED      (sy),
            .topLeftX     (tlx[g]),
            .topLeftY     (tly[g]),
            .speedX       (spx[g]),
            .speedY       (spy[g]),
            .edgeHitX     (hx[g]),
            .edgeHitY     (hy[g]),
            .state        (st[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        sof = 1'b1;
        tick();
        sof = 1'b0;
        tick();
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_load(input int x, input int y, input int vx, input int vy);
        ix = 11'(x);
        iy = 11'(y);
        sx = 16'(vx);
        sy = 16'(vy);
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sof = 1'b0; enable = 1'b1; load = 1'b0;
        tgx = 1'b0; tgy = 1'b0;
        ix = 11'sd280; iy = 11'sd100; sx = 16'sd30; sy = 16'sd0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_x", tlx[0], 280);
        chk("reset_y", tly[0], 100);
        chk("reset_spx", spx[0], 30);
        chk("reset_state", st[0], 0);
        chk("reset_hit", hx[0], 0);

        // 64 frames of +30/64 px: floor behaviour then +30 px total
        for (int i = 0; i < 64; i++) begin
            frame();
            if (i == 1) chk("floor_2fr", tlx[0], 280);
            if (i == 2) chk("floor_3fr", tlx[0], 281);
        end
        chk("accum_64fr", tlx[0], 310);
        chk("accum_y_still", tly[0], 100);

        // toggle held 3 cycles within one frame negates once
        tgx = 1'b1;
        tick(); tick(); tick();
        tgx = 1'b0;
        tick();
        chk("toggle_once", spx[0], -30);

        // toggle on the frame pulse: negate, but move with old speed
        tgx = 1'b1; sof = 1'b1;
        tick();
        tgx = 1'b0; sof = 1'b0;
        tick();
        chk("toggle_sof_spd", spx[0], 30);
        chk("toggle_sof_pos", tlx[0], 309);
        tgx = 1'b1; tick(); tgx = 1'b0; tick();
        chk("toggle_again", spx[0], -30);
        tgx = 1'b1; tick(); tgx = 1'b0; tick();
        chk("toggle_blocked", spx[0], -30);

        // bounce at X_MAX=300
        do_load(299, 100, 128, 0);
        chk("load_b300", tlx[1], 299);
        sof = 1'b1;
        tick();
        sof = 1'b0;
        chk("bounce_pos", tlx[1], 300);
        chk("bounce_spd", spx[1], -128);
        chk("bounce_hit", hx[1], 1);
        chk("nobounce_639", tlx[0], 301);
        chk("nobounce_hit", hx[0], 0);
        tick();
        chk("bounce_hit_1cyc", hx[1], 0);

        // wrap and stop at X_MAX=639
        do_load(639, 100, 64, 5);
        sof = 1'b1;
        tick();
        sof = 1'b0;
        chk("wrap_pos", tlx[2], 0);
        chk("wrap_spd", spx[2], 64);
        chk("wrap_hit", hx[2], 1);
        chk("stop_pos", tlx[3], 639);
        chk("stop_spx", spx[3], 0);
        chk("stop_spy", spy[3], 0);
        chk("stop_state", st[3], 2);
        chk("stop_hit", hx[3], 1);
        tick();
        frame();
        tgx = 1'b1; tick(); tgx = 1'b0;
        chk("stopped_hold", st[3], 2);
        chk("stopped_pos", tlx[3], 639);
        do_load(639, 100, 64, 5);
        chk("stop_load_run", st[3], 0);
        chk("stop_load_spd", spx[3], 64);

        // both axes hit in the same frame
        do_load(639, 479, 64, 64);
        sof = 1'b1;
        tick();
        sof = 1'b0;
        chk("both_hx", hx[0], 1);
        chk("both_hy", hy[0], 1);
        chk("both_y", tly[0], 479);
        chk("both_spy", spy[0], -64);

        // zero speed at the bound never fires an edge
        do_load(639, 479, 0, 0);
        sof = 1'b1;
        tick();
        sof = 1'b0;
        chk("zero_spd_hit", hx[0], 0);
        chk("zero_spd_pos", tlx[0], 639);

        // load beats startOfFrame
        ix = 11'sd280; iy = 11'sd100; sx = 16'sd128; sy = 16'sd0;
        load = 1'b1; sof = 1'b1;
        tick();
        load = 1'b0; sof = 1'b0;
        chk("load_sof_pos", tlx[0], 280);

        // paused for 5 frames with toggle held
        enable = 1'b0;
        tick();
        chk("paused_state", st[0], 1);
        tgx = 1'b1;
        for (int i = 0; i < 5; i++) frame();
        tgx = 1'b0;
        chk("paused_pos", tlx[0], 280);
        chk("paused_spd", spx[0], 128);
        enable = 1'b1;
        tick();
        chk("resume_state", st[0], 0);

        // reset mid-run after 10 frames
        do_load(280, 100, 128, 64);
        for (int i = 0; i < 10; i++) frame();
        chk("run10_x", tlx[0], 300);
        chk("run10_y", tly[0], 110);
        sof = 1'b1; load = 1'b1; tgx = 1'b1; reset = 1'b1;
        tick();
        sof = 1'b0; load = 1'b0; tgx = 1'b0; reset = 1'b0;
        chk("rst_mid_x", tlx[0], 280);
        chk("rst_mid_y", tly[0], 100);
        chk("rst_mid_state", st[0], 0);
        chk("rst_mid_hit", hx[0], 0);
        chk("rst_mid_spx", spx[0], 128);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rope_move2d.md
ROPE_MOVE2D -- requirements
Module: rope_move2d

Interface
REQ-001 Parameters SHALL be: FRAC_BITS, 6, fixed-point fraction bits (position and speed scaled by 2^FRAC_BITS).
REQ-002 POS_W, 11, signed pixel-coordinate width of topLeftX/topLeftY.
REQ-003 X_MIN/X_MAX, 0/639, and Y_MIN/Y_MAX, 0/479: inclusive pixel bounds per axis.
REQ-004 EDGE_MODE, EDGE_BOUNCE, edge_mode_t applied to both axes (EDGE_BOUNCE, EDGE_WRAP, EDGE_STOP).
REQ-005 Ports SHALL be: clk  in  1  system clock; one clock domain.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 startOfFrame  in  1  one-cycle pulse per frame.
REQ-008 enable  in  1  high = move, low = pause.
REQ-009 load  in  1  reload initial position/speed.
REQ-010 dirToggleX, dirToggleY  in  1 each  collision toggle per axis.
REQ-011 INITIAL_X, INITIAL_Y  in  POS_W signed  start pixel position.
REQ-012 X_SPEED, Y_SPEED  in  16 signed  start speed, fixed-point units per frame.
REQ-013 topLeftX, topLeftY  out  POS_W signed  current pixel position.
REQ-014 speedX, speedY  out  16 signed  current speeds.
REQ-015 edgeHitX, edgeHitY  out  1 each  one-cycle pulse on bound event.
REQ-016 state  out  2  current move_state_t.

Function
REQ-017 Internal position SHALL be held per axis as signed POS_W+FRAC_BITS+1 bits equal to pixel * 2^FRAC_BITS.
REQ-018 topLeftX/Y SHALL be the internal position arithmetically shifted right by FRAC_BITS (floor), combinational from registers.
REQ-019 The FSM SHALL have states RUN, PAUSED, STOPPED: RUN->PAUSED when enable=0; PAUSED->RUN when enable=1; any->STOPPED on EDGE_STOP bound hit; STOPPED exits only on load or reset.
REQ-020 On startOfFrame in RUN, each axis SHALL compute next = pos + speed using the speed registered before that cycle; the new position SHALL be visible on topLeft the following cycle.
REQ-021 If next lies inside [MIN, MAX] * 2^FRAC_BITS, pos SHALL become next.
REQ-022 EDGE_BOUNCE: pos SHALL clamp to the violated bound, speed SHALL negate, and edgeHit SHALL pulse for one cycle.
REQ-023 EDGE_WRAP: pos SHALL become the opposite bound (exceed MAX -> MIN, below MIN -> MAX), speed SHALL be unchanged, and edgeHit SHALL pulse.
REQ-024 EDGE_STOP: pos SHALL clamp, both speeds SHALL become 0, edgeHit SHALL pulse, and state SHALL become STOPPED.
REQ-025 In RUN, dirToggle high SHALL negate that axis speed at most once per frame; a per-axis flag SHALL block repeats until cleared by startOfFrame.
REQ-026 When toggle and startOfFrame coincide, the negation SHALL apply, the flag SHALL clear, and the position update SHALL use the pre-negation speed.
REQ-027 dirToggle SHALL be ignored in PAUSED and STOPPED, and flags SHALL be cleared while PAUSED.
REQ-028 load SHALL set pos = INITIAL*2^FRAC_BITS, speed = X/Y_SPEED, clear flags, and set state to RUN if enable=1 else PAUSED.
REQ-029 load SHALL have priority over startOfFrame, toggle and bound logic in the same cycle.
REQ-030 Speed 0 SHALL never produce an edge event.
REQ-031 A bound violated by both axes in one frame SHALL pulse both edgeHit outputs in the same cycle.

Reset
REQ-032 On reset=1 at a clk edge, pos SHALL take INITIAL values, speeds SHALL take X/Y_SPEED, flags and edgeHit SHALL be 0, and state SHALL be RUN; reset SHALL override load and all other inputs, including mid-frame.

Structure
REQ-033 Package rope_pkg SHALL hold edge_mode_t, move_state_t and the speed width constant (16).
REQ-034 Per-axis arithmetic (accumulate, bound check, toggle flag) SHALL live in sub-module rope_axis, instantiated twice; the FSM SHALL live in rope_move2d.

Verification
REQ-035 INITIAL_X=280, X_SPEED=30, 64 startOfFrame pulses in RUN -> topLeftX=310.
REQ-036 X_SPEED=30, dirToggleX held 3 cycles within one frame -> speedX=-30, not +30; next frame toggle -> +30.
REQ-037 BOUNCE, X_MAX=300, INITIAL_X=299, X_SPEED=128, one frame -> topLeftX=300, speedX=-128, edgeHitX high exactly 1 cycle.
REQ-038 WRAP, INITIAL_X=639, X_SPEED=64, one frame -> topLeftX=0, speedX=64; STOP with same stimulus -> topLeftX=639, speeds 0, state=STOPPED; then load -> RUN.
REQ-039 load and startOfFrame in the same cycle -> topLeftX=INITIAL_X, no movement; enable=0 for 5 frames -> position unchanged, toggles ignored.
REQ-040 Reset asserted mid-run after 10 frames -> next cycle topLeft=INITIAL values, state=RUN, edgeHit=0.
